gray_seq_ctrl: RTL and testbench

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 114 +++++++++++
 tb/tb_gray_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - round-robin sequencer driving an external Gray counter for a granted step count
module gray_seq_ctrl #(
    parameter int N     = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             pause,
    input  logic [N-1:0]     gray_in,
    output logic [1:0]       gnt,
    output logic             cnt_rst,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [N-1:0]     snap_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             idx_q, idx_d;
    logic             last_q, last_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [N-1:0]     snap_q, snap_d;
    logic             pick;
    logic [1:0]       gnt_vec;

    // last_q holds the requester served most recently; reset value 1 lets requester 0 win first
    always_comb begin
        pick = 1'b0;
        unique case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_q;
            default: pick = 1'b0;
        endcase
    end

    assign gnt_vec = idx_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        rem_d   = rem_q;
        snap_d  = snap_q;
        gnt     = 2'b00;
        cnt_rst = 1'b0;
        cnt_en  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (req != 2'b00) begin
                    idx_d   = pick;
                    rem_d   = pick ? len1 : len0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                gnt     = gnt_vec;
                cnt_rst = 1'b1;
                state_d = (rem_q != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                gnt    = gnt_vec;
                cnt_en = ~pause;
                if (!pause) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                snap_d  = gray_in;
                last_d  = idx_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 1'b0;
            last_q  <= 1'b1;
            rem_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            snap_q  <= snap_d;
        end
    end

    assign done_id  = done & idx_q;
    assign snap_out = snap_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb/tb_gray_seq_ctrl.sv - randomized self-checking bench for gray_seq_ctrl against a transaction model
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] len0, len1;
    logic       pause;
    logic [7:0] gray_in;
    logic [1:0] gnt;
    logic       cnt_rst, cnt_en, busy, done, done_id;
    logic [7:0] snap_out;
    logic [7:0] bin_q;

    int n_chk  = 0;
    int n_pass = 0;
    int last_served;
    int exp_snap;

    gray_seq_ctrl #(.N(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1),
        .pause(pause), .gray_in(gray_in), .gnt(gnt), .cnt_rst(cnt_rst),
        .cnt_en(cnt_en), .busy(busy), .done(done), .done_id(done_id),
        .snap_out(snap_out)
    );

    always #5 clk = ~clk;

    // the controlled Gray counter
    always_ff @(posedge clk) begin
        if (rst || cnt_rst) bin_q <= 8'd0;
        else if (cnt_en)    bin_q <= bin_q + 8'd1;
    end
    assign gray_in = bin_q ^ (bin_q >> 1);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // one operation: current cycle is IDLE; model predicts winner, enable pattern and snapshot
    task automatic run_op(input logic [1:0] r, input int l0, input int l1,
                          input int pct, input logic [31:0] pmask, input bit scramble);
        int  win, len, steps, idx;
        bit  p;
        req   = r;
        len0  = l0[7:0];
        len1  = l1[7:0];
        pause = 1'($urandom_range(0, 1));
        if (r == 2'b01)      win = 0;
        else if (r == 2'b10) win = 1;
        else                 win = (last_served == 0) ? 1 : 0;
        len = (win == 1) ? l1 : l0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_gnt", gnt, 0);
        chk("idle_snap", snap_out, exp_snap);
        next_cycle();
        pause = 1'($urandom_range(0, 1));
        if (scramble) begin
            req  = 2'($urandom);
            len0 = 8'($urandom);
            len1 = 8'($urandom);
        end
        @(negedge clk);
        chk("clear_gnt", gnt, 1 << win);
        chk("clear_rst", cnt_rst, 1);
        chk("clear_en", cnt_en, 0);
        chk("clear_busy", busy, 1);
        steps = 0;
        idx   = 0;
        while (steps < len && idx < 4000) begin
            next_cycle();
            p = (idx < 32 && pmask[idx]) || ($urandom_range(0, 99) < pct);
            pause = p;
            if (scramble) req = 2'($urandom);
            @(negedge clk);
            chk("run_en", cnt_en, !p);
            chk("run_gnt", gnt, 1 << win);
            chk("run_rst", cnt_rst, 0);
            chk("run_done", done, 0);
            if (!p) steps++;
            idx++;
        end
        if (idx >= 4000) chk("run_bound", 0, 1);
        next_cycle();
        pause = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("done", done, 1);
        chk("done_id", done_id, win);
        chk("done_gnt", gnt, 0);
        chk("done_en", cnt_en, 0);
        last_served = win;
        exp_snap    = (len ^ (len >> 1)) & 8'hff;
        next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        req   = 2'b11;
        len0  = 8'd7;
        len1  = 8'd9;
        pause = 1'b1;
        last_served = 1;
        exp_snap    = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_en", cnt_en, 0);
        chk("rst_cntrst", cnt_rst, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_snap", snap_out, 0);
        next_cycle();
        rst = 1'b0;

        run_op(2'b11, 3, 2, 0, 32'h0, 1'b0);
        run_op(2'b11, 3, 2, 0, 32'h0, 1'b0);
        chk("rr_snap", snap_out, 8'h03);
        run_op(2'b01, 5, 9, 0, 32'h0, 1'b0);
        chk("len5_snap", snap_out, 8'h07);
        run_op(2'b10, 6, 0, 0, 32'h0, 1'b0);
        run_op(2'b01, 4, 1, 0, 32'h0000_000e, 1'b0);
        chk("pause_snap", snap_out, 8'h06);
        run_op(2'b01, 255, 3, 0, 32'h0, 1'b1);
        chk("len255_snap", snap_out, 8'h80);
        run_op(2'b01, 2, 2, 0, 32'h0000_0002, 1'b0);

        // reset mid-RUN abandons the operation
        req  = 2'b01;
        len0 = 8'd10;
        next_cycle();
        req = 2'b00;
        for (int i = 0; i < 4; i++) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_en", cnt_en, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_snap", snap_out, 0);
        last_served = 1;
        exp_snap    = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            @(negedge clk);
            chk("mid_rst_nodone", done, 0);
        end
        next_cycle();
        run_op(2'b01, 1, 4, 0, 32'h0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            run_op(2'($urandom_range(1, 3)), $urandom_range(0, 12), $urandom_range(0, 12),
                   $urandom_range(0, 40), 32'h0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
